// File: rtl/sample_frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer and its output FIFO.
package sample_frame_sequencer_pkg;

  localparam int unsigned VOICE_OP_ID_W               = 8;
  localparam int unsigned SAMPLE_W                    = 16;
  localparam int unsigned NUM_VOICE_OPERATORS_DEFAULT = 192;

  typedef logic [VOICE_OP_ID_W-1:0] VoiceOperatorID_t;

  localparam VoiceOperatorID_t IDLE_VOICE_OPERATOR_ID = 8'hfe;
  localparam VoiceOperatorID_t FRAME_END_ID           = 8'hff;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    END,
    WAIT
  } SequencerState_t;

endpackage

// File: rtl/sample_output_fifo.sv
// First-word-fall-through sample FIFO; a pop frees a slot for a same-cycle push even when full.
module sample_output_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_PushData,
  input  logic             i_Pop,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [WIDTH-1:0] o_HeadData
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_Empty    = (wr_ptr_q == rd_ptr_q);
  assign o_Full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = i_Pop && !o_Empty;
  assign do_push    = i_Push && (!o_Full || do_pop);
  assign o_HeadData = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_PushData;
    end
  end

endmodule

// File: rtl/sample_frame_sequencer.sv
// Frame controller: issues operator IDs per sample tick, collects the finished sample into a FIFO.
module sample_frame_sequencer
  import sample_frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_VOICE_OPERATORS = NUM_VOICE_OPERATORS_DEFAULT,
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter int unsigned MAX_WAIT            = 64
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_SampleTick,
  output VoiceOperatorID_t    o_VoiceOperator,
  output logic                o_OperatorValid,
  input  logic                i_SampleReady,
  input  logic [SAMPLE_W-1:0] i_Sample,
  output logic                o_SampleValid,
  output logic [SAMPLE_W-1:0] o_Sample,
  input  logic                i_SampleAccept,
  input  logic                i_ClearStatus,
  output logic                o_Busy,
  output logic                o_Overrun,
  output logic                o_FifoOverflow,
  output logic                o_Timeout
);

  localparam int unsigned      WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam VoiceOperatorID_t LAST_ID    = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  SequencerState_t   state_q, state_d;
  VoiceOperatorID_t  op_cnt_q, op_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  VoiceOperatorID_t  voice_op_q, voice_op_d;
  logic              op_valid_q, op_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              fifo_ovf_q, fifo_ovf_d;
  logic              timeout_q, timeout_d;

  logic push_c, set_timeout_c, set_overrun_c, set_fifo_ovf_c;
  logic fifo_full, fifo_empty, pop_c;

  assign pop_c = !fifo_empty && i_SampleAccept;

  // Next-state, registered-output and sticky-flag logic.
  always_comb begin
    state_d        = state_q;
    op_cnt_d       = op_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    voice_op_d     = IDLE_VOICE_OPERATOR_ID;
    op_valid_d     = 1'b0;
    push_c         = 1'b0;
    set_timeout_c  = 1'b0;
    set_overrun_c  = i_SampleTick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (i_SampleTick) begin
          state_d    = RUN;
          op_cnt_d   = '0;
          voice_op_d = '0;
          op_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (op_cnt_q == LAST_ID) begin
          state_d    = END;
          voice_op_d = FRAME_END_ID;
        end else begin
          op_cnt_d   = op_cnt_q + 8'd1;
          voice_op_d = op_cnt_q + 8'd1;
          op_valid_d = 1'b1;
        end
      end
      END: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (i_SampleReady) begin
          push_c  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_LIMIT) begin
            set_timeout_c = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    set_fifo_ovf_c = push_c && fifo_full && !pop_c;
    busy_d         = (state_d != IDLE);

    // Set dominates a simultaneous clear.
    overrun_d  = (overrun_q  && !i_ClearStatus) || set_overrun_c;
    fifo_ovf_d = (fifo_ovf_q && !i_ClearStatus) || set_fifo_ovf_c;
    timeout_d  = (timeout_q  && !i_ClearStatus) || set_timeout_c;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      op_cnt_q   <= '0;
      wait_cnt_q <= '0;
      voice_op_q <= IDLE_VOICE_OPERATOR_ID;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      fifo_ovf_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_cnt_q   <= op_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      voice_op_q <= voice_op_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      fifo_ovf_q <= fifo_ovf_d;
      timeout_q  <= timeout_d;
    end
  end

  sample_output_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Push     (push_c),
    .i_PushData (i_Sample),
    .i_Pop      (i_SampleAccept),
    .o_Full     (fifo_full),
    .o_Empty    (fifo_empty),
    .o_HeadData (o_Sample)
  );

  assign o_VoiceOperator = voice_op_q;
  assign o_OperatorValid = op_valid_q;
  assign o_SampleValid   = !fifo_empty;
  assign o_Busy          = busy_q;
  assign o_Overrun       = overrun_q;
  assign o_FifoOverflow  = fifo_ovf_q;
  assign o_Timeout       = timeout_q;

endmodule

// File: doc/sample_frame_sequencer.md
Name: sample_frame_sequencer

Overview:
Frame-level controller for the operator/sample pipeline.
- On each sample-rate tick, issues one voice-operator ID per cycle (0..N-1), then the frame-end marker 8'hff, into the operator pipeline.
- Waits for the sample generator's sample-ready pulse and captures the finished 16-bit sample into a small output FIFO.
- The FIFO feeds the DAC/serializer through a valid/ready handshake.
- Reports overrun, FIFO-overflow and timeout via sticky status flags.

Parameters:
NUM_VOICE_OPERATORS, 192, operator slots issued per frame (1..254)
FIFO_DEPTH, 4, output sample FIFO entries (power of two, ≥2)
MAX_WAIT, 64, cycles allowed in WAIT for sample-ready before abort

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_SampleTick  in  1  one-cycle frame-start request at sample rate
o_VoiceOperator  out  8  VoiceOperatorID_t driven into the pipeline
o_OperatorValid  out  1  high while o_VoiceOperator is a real operator ID (0..N-1)
i_SampleReady  in  1  sample-ready pulse from the sample generator
i_Sample  in  16  signed sample from the sample generator
o_SampleValid  out  1  FIFO non-empty
o_Sample  out  16  FIFO head sample (signed)
i_SampleAccept  in  1  consumer ready; pop when o_SampleValid && i_SampleAccept
i_ClearStatus  in  1  clears all sticky flags
o_Busy  out  1  state != IDLE
o_Overrun  out  1  sticky: tick arrived while not IDLE
o_FifoOverflow  out  1  sticky: sample dropped because FIFO full
o_Timeout  out  1  sticky: WAIT exceeded MAX_WAIT

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; o_VoiceOperator=8'hfe (IDLE_ID); o_OperatorValid=0.
  - FIFO emptied; o_SampleValid=0; o_Sample=0; all sticky flags 0; o_Busy=0.
  - Reset mid-frame aborts the frame with no FIFO push.
- States: IDLE → RUN → END → WAIT → IDLE. All outputs are registered.
- IDLE:
  - o_VoiceOperator=8'hfe; o_OperatorValid=0.
  - i_SampleTick → RUN with op counter=0.
- RUN:
  - o_VoiceOperator=counter; o_OperatorValid=1; counter increments each cycle.
  - After emitting N-1 → END.
  - Tick at cycle t gives ID 0 at t+1 and ID N-1 at t+N.
- END:
  - o_VoiceOperator=8'hff for exactly one cycle (t+N+1); o_OperatorValid=0.
  - → WAIT with wait counter=0.
- WAIT:
  - o_VoiceOperator=8'hfe; o_OperatorValid=0.
  - On i_SampleReady: push i_Sample → IDLE.
  - Otherwise increment the wait counter. At MAX_WAIT: set o_Timeout, no push → IDLE.
- i_SampleReady outside WAIT: ignored.
- i_SampleTick in any state other than IDLE: dropped; o_Overrun set. The frame in progress is unaffected.
- Tick in the same cycle the FSM returns from WAIT to IDLE: dropped. The FSM must be in IDLE when the tick is sampled.
- FIFO:
  - First-word-fall-through; o_Sample is valid whenever o_SampleValid.
  - Push and pop in the same cycle are both performed, including when full: the pop frees the slot and the push is accepted with no overflow.
  - Push when full with no pop: sample dropped, o_FifoOverflow set.
  - Pop when empty: no effect.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around; full/empty are derived from the MSB and equality comparison.
- Sticky flags: i_ClearStatus clears them. If set and clear occur in the same cycle, set wins.
- Frame period: N+2+(ready latency) cycles. A tick period shorter than this yields o_Overrun.

Decomposition:
- In synth.svh:
  - VoiceOperatorID_t (8 bit)
  - NUM_VOICE_OPERATORS
  - IDLE_VOICE_OPERATOR_ID=8'hfe
  - FRAME_END_ID=8'hff
  - SequencerState_t enum {IDLE, RUN, END, WAIT}
- Sub-module: sample_output_fifo (parameterised DEPTH/WIDTH, push/pop/full/empty, FWFT). Instantiated once.
- FSM and counters stay in the top module.

Test Plan:
- N=4, FIFO_DEPTH=4, MAX_WAIT=64 unless stated.
- Basic frame: tick at t=10, i_SampleReady with 16'h1234 at t=18 → IDs 0,1,2,3 at t=11..14 with valid=1; 8'hff at t=15; o_Busy low from t=19; o_SampleValid=1 with o_Sample=16'h1234; accept pops it → o_SampleValid=0.
- Overrun: second tick at t=12 during RUN → ID sequence unchanged; o_Overrun=1 until i_ClearStatus; set+clear same cycle → remains 1.
- FIFO full: 5 frames, samples 1..5, i_SampleAccept=0 → FIFO holds 1..4; sample 5 dropped; o_FifoOverflow=1. Then drain yields 1,2,3,4 in order. Separately, full FIFO with push+pop in the same cycle → no overflow flag.
- Timeout: MAX_WAIT=8, never assert i_SampleReady → o_Timeout=1 exactly 8 cycles after WAIT entry; FSM returns to IDLE; no push; a late i_SampleReady is ignored.
- Reset mid-RUN: assert i_Reset while ID 2 is being issued → next cycle o_VoiceOperator=8'hfe, o_OperatorValid=0, FIFO empty, all flags 0; a subsequent tick runs a clean frame.
